fifo_arbiter: RTL and testbench
===============================

FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of write requesters.
REQ-002 The block SHALL have parameter W, default 4, giving the data width per requester.
REQ-003 The block SHALL have port clock  input  1  rising-edge clock.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req  input  N  per-requester level request; the requester holds its data stable while req is high.
REQ-006 The block SHALL have port data  input  N*W  requester data, with slice i at bits [i*W+W-1 : i*W].
REQ-007 The block SHALL have port gnt  output  N  one-hot grant, high only in the PUSH cycle.
REQ-008 The block SHALL have port fifo_en_in  output  1  push strobe to the FIFO, which detects its rising edge.
REQ-009 The block SHALL have port fifo_wdata  output  W  data presented to the FIFO.
REQ-010 The block SHALL have port fifo_full  input  1  FIFO full flag.
REQ-011 The block SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-012 The block SHALL have port pop_req  input  1  consumer level request to remove one entry.
REQ-013 The block SHALL have port fifo_en_out  output  1  pop strobe to the FIFO.
REQ-014 The block SHALL have port pop_ack  output  1  one-cycle pulse; FIFO output is valid in this cycle.
REQ-015 The block SHALL have port busy  output  1  high when either FSM is not idle.

Function
REQ-016 The push FSM SHALL have three states, IDLE, PUSH and RECOVER, and fifo_en_in SHALL be high only in PUSH.
REQ-017 In IDLE or RECOVER, when any req bit is high and fifo_full is low, the push FSM SHALL select one requester and enter PUSH at the next edge; otherwise it SHALL enter IDLE.
REQ-018 PUSH SHALL last exactly one cycle and SHALL then enter RECOVER unconditionally, so that a low cycle follows every strobe.
REQ-019 In PUSH, gnt[sel] SHALL be high and fifo_wdata SHALL equal data slice sel, registered at the selection edge.
REQ-020 Latency SHALL be one cycle (req sampled in cycle t, gnt in cycle t+1), with a maximum throughput of one push per 2 cycles.
REQ-021 Default selection SHALL be round-robin: the search starts at the index after the last granted requester and wraps from N-1 to 0.
REQ-022 When fifo_full is high in IDLE or RECOVER, no grant SHALL be issued and no requester data is lost; requests stay pending.
REQ-023 A requester dropping req before a grant SHALL be ignored; a requester holding req after its gnt pulse SHALL be treated as a new request.
REQ-024 The pop FSM SHALL have three states, P_IDLE, P_STROBE and P_ACK.
REQ-025 In P_IDLE, pop_req high with fifo_empty low SHALL enter P_STROBE, where fifo_en_out is high for exactly one cycle.
REQ-026 P_ACK SHALL drive pop_ack high with fifo_en_out low for one cycle and then return to P_IDLE.
REQ-027 When pop_req is high and fifo_empty is high, the pop FSM SHALL stay in P_IDLE with no strobe.
REQ-028 The push and pop FSMs SHALL run independently, and simultaneous PUSH and P_STROBE SHALL be permitted.
REQ-029 gnt SHALL be one-hot or zero in every cycle.

Reset
REQ-030 While reset is high, both FSMs SHALL go idle and gnt, fifo_en_in, fifo_wdata, fifo_en_out, pop_ack and busy SHALL all be 0.
REQ-031 On reset, the round-robin last-granted pointer SHALL be set to N-1, so requester 0 is searched first.
REQ-032 A reset asserted during PUSH or P_STROBE SHALL abort the operation at that edge, with no further strobe or ack.

Configuration
REQ-033 When macro FIFO_ARB_FIXED_PRIO_EN is defined, selection SHALL be fixed priority (lowest index wins) and the round-robin pointer SHALL be omitted.
REQ-034 When FIFO_ARB_FIXED_PRIO_EN is not defined, selection SHALL be round-robin per REQ-021.

Verification
REQ-035 Bench: reset, then req=4'b0001, data[3:0]=5 -> gnt=0001 and fifo_wdata=5 one cycle later, RECOVER next, no second grant after req drops.
REQ-036 Bench: req=4'b1111 held, requesters dropping req after their gnt -> grants 0001, 0010, 0100, 1000 on alternate cycles (macro undefined); with the macro, 0001 first and then the next-lowest requester still pending.
REQ-037 Bench: fifo_full=1 with req=4'b0010 for 10 cycles -> gnt=0 and fifo_en_in=0 throughout; full drops -> gnt=0010 on the next cycle.
REQ-038 Bench: pop_req=1 with fifo_empty=0 -> fifo_en_out high 1 cycle, pop_ack the next cycle; with fifo_empty=1 -> no strobe.
REQ-039 Bench: push and pop requested in the same cycle -> fifo_en_in and fifo_en_out both high in the same cycle.
REQ-040 Bench: reset asserted in the PUSH cycle -> all outputs 0 at the next edge, and the next grant after release goes to requester 0.

Source files
------------

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: arbitrates N write requesters onto one FIFO push port.
// It also sequences consumer pops as strobe-then-ack.
// Build option FIFO_ARB_FIXED_PRIO_EN: when defined, the lowest pending
// index wins. When undefined (the default), selection is round-robin,
// starting after the last granted requester.
//
// Push FSM
//   state   | meaning
//   IDLE    | no push in flight; requests are sampled here
//   PUSH    | fifo_en_in high, gnt[sel] high, fifo_wdata valid (1 cycle)
//   RECOVER | strobe low so the FIFO sees a fresh rising edge next push;
//           | requests are sampled here as well
// Pop FSM
//   state    | meaning
//   P_IDLE   | waiting for pop_req with a non-empty FIFO
//   P_STROBE | fifo_en_out high for one cycle
//   P_ACK    | pop_ack high; FIFO output data valid
module fifo_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   gnt,
  output logic           fifo_en_in,
  output logic [W-1:0]   fifo_wdata,
  input  logic           fifo_full,
  input  logic           fifo_empty,
  input  logic           pop_req,
  output logic           fifo_en_out,
  output logic           pop_ack,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, PUSH, RECOVER} push_state_t;
  typedef enum logic [1:0] {P_IDLE, P_STROBE, P_ACK} pop_state_t;

  push_state_t   push_state, push_next;
  pop_state_t    pop_state, pop_next;
  logic [IW-1:0] sel_q;
  logic [IW-1:0] pick;
  logic [W-1:0]  wdata_q;
  logic [W-1:0]  pick_data;
  logic          found;
  logic          take;

`ifdef FIFO_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest-indexed pending requester wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] last_q;
  logic [IW-1:0] idx;

  // Round-robin: search from the requester after last_q, wrapping at N-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_q) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
`endif

  // Capture the chosen requester's data slice at the selection edge.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N; i++) begin
      if (pick == IW'(i)) pick_data = data[i*W +: W];
    end
  end

  // A push is started only from IDLE/RECOVER, and only with room in the FIFO.
  assign take = (push_state != PUSH) && found && !fifo_full;

  // Push FSM state and selection registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      push_state <= IDLE;
      sel_q      <= '0;
      wdata_q    <= '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      last_q     <= IW'(N - 1);
`endif
    end else begin
      push_state <= push_next;
      if (take) begin
        sel_q   <= pick;
        wdata_q <= pick_data;
`ifndef FIFO_ARB_FIXED_PRIO_EN
        last_q  <= pick;
`endif
      end
    end
  end

  // Push FSM next state and outputs; outputs are forced low while in reset.
  always_comb begin
    push_next  = push_state;
    gnt        = '0;
    fifo_en_in = 1'b0;
    fifo_wdata = '0;
    case (push_state)
      IDLE, RECOVER: push_next = take ? PUSH : IDLE;
      PUSH:          push_next = RECOVER;
      default:       push_next = IDLE;
    endcase
    if (!reset && push_state == PUSH) begin
      fifo_en_in = 1'b1;
      fifo_wdata = wdata_q;
      for (int i = 0; i < N; i++) gnt[i] = (sel_q == IW'(i));
    end
  end

  // Pop FSM state register.
  always_ff @(posedge clock) begin
    if (reset) pop_state <= P_IDLE;
    else       pop_state <= pop_next;
  end

  // Pop FSM next state and outputs; outputs are forced low while in reset.
  always_comb begin
    pop_next    = pop_state;
    fifo_en_out = 1'b0;
    pop_ack     = 1'b0;
    case (pop_state)
      P_IDLE:   if (pop_req && !fifo_empty) pop_next = P_STROBE;
      P_STROBE: pop_next = P_ACK;
      P_ACK:    pop_next = P_IDLE;
      default:  pop_next = P_IDLE;
    endcase
    if (!reset) begin
      fifo_en_out = (pop_state == P_STROBE);
      pop_ack     = (pop_state == P_ACK);
    end
  end

  // Busy whenever either sequence is away from its idle state.
  assign busy = !reset && ((push_state != IDLE) || (pop_state != P_IDLE));

endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: directed scenarios with literal expectations, then
// randomized traffic. A cycle-level behavioural model tracks the expected
// outputs and is compared with the DUT on every cycle.
module tb_fifo_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic           fifo_full = 1'b0;
  logic           fifo_empty = 1'b1;
  logic           pop_req = 1'b0;
  logic [N-1:0]   gnt;
  logic           fifo_en_in;
  logic [W-1:0]   fifo_wdata;
  logic           fifo_en_out;
  logic           pop_ack;
  logic           busy;

  fifo_arbiter #(.N(N), .W(W)) dut (
    .clock(clock), .reset(reset), .req(req), .data(data), .gnt(gnt),
    .fifo_en_in(fifo_en_in), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .pop_req(pop_req), .fifo_en_out(fifo_en_out),
    .pop_ack(pop_ack), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model: m_push = a strobe is out this cycle, m_recover = one was out last cycle
  bit           m_push = 1'b0, m_recover = 1'b0, m_strobe = 1'b0, m_ack = 1'b0;
  int           m_idx = 0;
  int           m_last = N - 1;
  logic [W-1:0] m_wdata = '0;

  // literal expectations for the current cycle, set by the directed sequence
  bit           pin_en = 1'b0;
  string        pin_name = "";
  logic [N-1:0] pin_gnt = '0;
  bit           pin_in = 1'b0, pin_out = 1'b0, pin_ack = 1'b0;
  logic [W-1:0] pin_wdata = '0;

  function automatic int choose(logic [N-1:0] r, int last);
`ifdef FIFO_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  // Model: a push may start in any cycle that is not itself a push cycle.
  always @(posedge clock) begin
    int c;
    if (reset) begin
      m_push <= 1'b0; m_recover <= 1'b0; m_strobe <= 1'b0; m_ack <= 1'b0;
      m_last <= N - 1; m_idx <= 0;
    end else begin
      c = (!m_push && !fifo_full) ? choose(req, m_last) : -1;
      m_recover <= m_push;
      m_push    <= (c >= 0);
      if (c >= 0) begin
        m_idx   <= c;
        m_wdata <= data[c*W +: W];
        m_last  <= c;
      end
      m_ack    <= m_strobe;
      m_strobe <= !m_strobe && !m_ack && pop_req && !fifo_empty;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model (and pins) away from the active edge.
  always @(negedge clock) begin
    logic [N-1:0] eg;
    bit ein, eout, eack, ebusy;
    if (chk_en) begin
      eg = '0;
      if (!reset && m_push) eg[m_idx] = 1'b1;
      ein   = !reset && m_push;
      eout  = !reset && m_strobe;
      eack  = !reset && m_ack;
      ebusy = !reset && (m_push || m_recover || m_strobe || m_ack);
      chk("gnt", gnt, eg);
      chk("fifo_en_in", fifo_en_in, ein);
      if (ein) chk("fifo_wdata", fifo_wdata, m_wdata);
      if (reset) chk("fifo_wdata_rst", fifo_wdata, 0);
      chk("fifo_en_out", fifo_en_out, eout);
      chk("pop_ack", pop_ack, eack);
      chk("busy", busy, ebusy);
      chk("gnt_onehot0", $onehot0(gnt), 1);
      if (pin_en) begin
        chk({pin_name, ".gnt"}, gnt, pin_gnt);
        chk({pin_name, ".en_in"}, fifo_en_in, pin_in);
        chk({pin_name, ".en_out"}, fifo_en_out, pin_out);
        chk({pin_name, ".ack"}, pop_ack, pin_ack);
        if (pin_in) chk({pin_name, ".wdata"}, fifo_wdata, pin_wdata);
        chk({pin_name, ".model_gnt"}, eg, pin_gnt);
        chk({pin_name, ".model_out"}, {ein, eout, eack}, {pin_in, pin_out, pin_ack});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    pin_en = 1'b0;
  endtask

  task automatic pin(string nm, logic [N-1:0] g, bit ein, logic [W-1:0] wd, bit eo, bit ak);
    pin_name = nm; pin_gnt = g; pin_in = ein; pin_wdata = wd; pin_out = eo; pin_ack = ak;
    pin_en = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    pin("reset", '0, 0, '0, 0, 0);
    tick(); reset = 1'b0;
    pin("idle", '0, 0, '0, 0, 0);

    // single requester
    tick(); req = 4'b0001; data = 16'h0005;
    pin("t1_pre", '0, 0, '0, 0, 0);
    tick(); pin("t1_push", 4'b0001, 1, 4'h5, 0, 0); req = '0;
    tick(); pin("t1_recover", '0, 0, '0, 0, 0);
    repeat (3) begin tick(); pin("t1_quiet", '0, 0, '0, 0, 0); end

    // all four requesting, each drops after its grant
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    tick(); data = 16'hDCBA; req = 4'b1111;
    tick(); pin("t2_g0", 4'b0001, 1, 4'hA, 0, 0); req = 4'b1110;
    tick(); pin("t2_r0", '0, 0, '0, 0, 0);
    tick(); pin("t2_g1", 4'b0010, 1, 4'hB, 0, 0); req = 4'b1100;
    tick(); pin("t2_r1", '0, 0, '0, 0, 0);
    tick(); pin("t2_g2", 4'b0100, 1, 4'hC, 0, 0); req = 4'b1000;
    tick(); pin("t2_r2", '0, 0, '0, 0, 0);
    tick(); pin("t2_g3", 4'b1000, 1, 4'hD, 0, 0); req = '0;
    tick(); pin("t2_end", '0, 0, '0, 0, 0);

    // FIFO full holds off the grant
    tick(); fifo_full = 1'b1; req = 4'b0010; data = 16'h0070;
    pin("t3_full0", '0, 0, '0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(); pin("t3_full", '0, 0, '0, 0, 0);
    end
    fifo_full = 1'b0;
    tick(); pin("t3_release", 4'b0010, 1, 4'h7, 0, 0); req = '0;
    tick(); pin("t3_end", '0, 0, '0, 0, 0);

    // pop sequence, then pop against an empty FIFO
    tick(); fifo_empty = 1'b0; pop_req = 1'b1;
    pin("t4_pre", '0, 0, '0, 0, 0);
    tick(); pin("t4_strobe", '0, 0, '0, 1, 0); pop_req = 1'b0;
    tick(); pin("t4_ack", '0, 0, '0, 0, 1);
    tick(); pin("t4_done", '0, 0, '0, 0, 0);
    fifo_empty = 1'b1; pop_req = 1'b1;
    repeat (4) begin tick(); pin("t4_empty", '0, 0, '0, 0, 0); end
    pop_req = 1'b0; fifo_empty = 1'b0;

    // push and pop together
    tick(); req = 4'b0001; data = 16'h0003; pop_req = 1'b1;
    tick(); pin("t5_both", 4'b0001, 1, 4'h3, 1, 0); req = '0; pop_req = 1'b0;
    tick(); pin("t5_ack", '0, 0, '0, 0, 1);

    // reset during PUSH and P_STROBE
    tick(); req = 4'b0100; data = 16'h0900; pop_req = 1'b1;
    tick(); pin("t6_push", 4'b0100, 1, 4'h9, 1, 0); req = 4'b1111; pop_req = 1'b0;
    #5 reset = 1'b1;
    tick(); reset = 1'b0; pin("t6_aborted", '0, 0, '0, 0, 0);
    tick(); pin("t6_first", 4'b0001, 1, 4'h0, 0, 0); req = '0;
    tick(); tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (m_push && m_idx == i) begin
            if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          end else if ($urandom_range(15, 0) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(2, 0) == 0) begin
          req[i] = 1'b1;
          data[i*W +: W] = W'($urandom);
        end
      end
      fifo_full  = ($urandom_range(4, 0) == 0);
      fifo_empty = ($urandom_range(3, 0) == 0);
      pop_req    = ($urandom_range(1, 0) == 1);
      reset      = ($urandom_range(199, 0) == 0);
    end
    tick(); req = '0; pop_req = 1'b0; reset = 1'b0; fifo_full = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
